// File: rtl/mat_vec_mult_engine.sv
// mat_vec_mult_engine: ROWS x COLS matrix times COLS-element vector.
// The B vector is buffered through a valid/ready port. Matrix rows are then
// streamed from per-row show-ahead FIFOs on a skewed schedule: row r consumes
// column k at issue step t = r + k. Any active row whose FIFO is empty stalls
// the whole array. Each lane is a two-stage MAC: the product is registered,
// then accumulated.
module mat_vec_mult_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int SIGNED     = 0,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(COLS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                reuse_b,
  input  logic                                abort,
  input  logic                                b_valid,
  input  logic [DATA_WIDTH-1:0]               b_data,
  output logic                                b_ready,
  output logic [ROWS-1:0]                     fifo_rden,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]     fifo_data,
  input  logic [ROWS-1:0]                     fifo_empty,
  output logic [ROWS-1:0][ACC_WIDTH-1:0]      result,
  output logic                                result_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int LAST_T = ROWS + COLS - 2;
  localparam int T_W    = $clog2(ROWS + COLS);
  localparam int K_W    = $clog2(COLS);
  localparam int PROD_W = 2*DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD_B, COMPUTE, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [T_W-1:0]        t;
  logic [K_W-1:0]        b_idx;
  logic                  drain_cnt;
  logic [DATA_WIDTH-1:0] b_buf [COLS];
  logic [ROWS-1:0]       active;
  logic                  stall;
  logic                  issue;
  logic                  b_fire;
  logic                  start_ok;
  logic [PROD_W-1:0]     prod      [ROWS];
  logic [PROD_W-1:0]     prod_next [ROWS];
  logic [ACC_WIDTH-1:0]  acc       [ROWS];

  // Operand widening to the full product width, sign-aware when SIGNED.
  function automatic logic [PROD_W-1:0] widen(input logic [DATA_WIDTH-1:0] v);
    if (SIGNED != 0) return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    else             return {{DATA_WIDTH{1'b0}}, v};
  endfunction

  // Product widening to the accumulator width, sign-aware when SIGNED.
  function automatic logic [ACC_WIDTH-1:0] extend(input logic [PROD_W-1:0] p);
    if (SIGNED != 0) return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
    else             return {{(ACC_WIDTH-PROD_W){1'b0}}, p};
  endfunction

  assign start_ok  = (state == IDLE) && start;
  assign b_fire    = (state == LOAD_B) && b_valid && !abort;
  assign stall     = |(active & fifo_empty);
  assign issue     = (state == COMPUTE) && !stall && !abort;
  assign fifo_rden = issue ? active : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the status outputs decoded from the state.
  always_comb begin
    state_next = state;
    b_ready    = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = reuse_b ? COMPUTE : LOAD_B;
      LOAD_B: begin
        b_ready = 1'b1;
        if (b_fire && (b_idx == K_W'(COLS-1))) state_next = COMPUTE;
      end
      COMPUTE: if (issue && (t == T_W'(LAST_T))) state_next = DRAIN;
      DRAIN:   if (drain_cnt) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // Issue step, B write index and drain counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t         <= '0;
      b_idx     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (start_ok) begin
        t     <= '0;
        b_idx <= '0;
      end else begin
        if (issue)  t     <= t + T_W'(1);
        if (b_fire) b_idx <= b_idx + K_W'(1);
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // B buffer: written one element per beat; a partially loaded vector is discarded on abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < COLS; k++) b_buf[k] <= '0;
    end else if (b_fire) begin
      b_buf[b_idx] <= b_data;
    end else if (abort && (state == LOAD_B)) begin
      for (int k = 0; k < COLS; k++) b_buf[k] <= '0;
    end
  end

  // Rows with a live column at the current issue step (r <= t < r+COLS).
  always_comb begin
    active = '0;
    for (int r = 0; r < ROWS; r++)
      active[r] = (int'(t) >= r) && (int'(t) < r + COLS);
  end

  // Stage-1 operand: head element times B[t-r], zero when the lane does not issue.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      prod_next[r] = '0;
      if (issue && active[r])
        prod_next[r] = widen(fifo_data[r]) * widen(b_buf[K_W'(t - T_W'(r))]);
    end
  end

  // MAC pipeline: register the product, then fold it into the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        prod[r] <= '0;
        acc[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        prod[r] <= abort ? '0 : prod_next[r];
        acc[r]  <= start_ok ? '0 : acc[r] + extend(prod[r]);
      end
    end
  end

  // result_valid rises on entry to DONE and holds until a new start or an abort.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 result_valid <= 1'b0;
    else if (start_ok || (abort && state != IDLE)) result_valid <= 1'b0;
    else if (state_next == DONE)                result_valid <= 1'b1;
  end

  // Results are a direct view of the accumulators.
  always_comb begin
    for (int r = 0; r < ROWS; r++) result[r] = acc[r];
  end

endmodule

// File: tb/tb_mat_vec_mult_engine.sv
// Testbench for mat_vec_mult_engine: an unsigned and a signed instance share
// all inputs. Expected results are computed by a dot-product model and queued
// when a job is launched, then popped when done is seen.
module tb_mat_vec_mult_engine;

  localparam int DW = 8;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int AW = 2*DW + $clog2(C);

  typedef struct packed {
    logic [R-1:0][AW-1:0] res_u;
    logic [R-1:0][AW-1:0] res_s;
    logic [31:0]          done_at;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n, start, reuse_b, abort, b_valid;
  logic [DW-1:0]        b_data;
  logic                 b_ready, b_ready_s;
  logic [R-1:0]         fifo_rden, fifo_rden_s;
  logic [R-1:0][DW-1:0] fifo_data;
  logic [R-1:0]         fifo_empty;
  logic [R-1:0][AW-1:0] result, result_s;
  logic                 result_valid, result_valid_s;
  logic                 busy, busy_s, done, done_s;

  logic [DW-1:0] a_mem   [R][C];
  logic [DW-1:0] b_drive [C];
  logic [DW-1:0] b_model [C];
  int            rd_ptr  [R];
  int            pop_cnt [R];
  int            underflow;
  logic          fifo_clear;
  logic [R-1:0]  force_empty;
  exp_t          sb [$];
  int            checks_total;
  int            checks_passed;

  always #5 clk = ~clk;

  mat_vec_mult_engine #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_b(reuse_b), .abort(abort),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .fifo_rden(fifo_rden), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .result(result), .result_valid(result_valid), .busy(busy), .done(done));

  mat_vec_mult_engine #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_b(reuse_b), .abort(abort),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready_s),
    .fifo_rden(fifo_rden_s), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .result(result_s), .result_valid(result_valid_s), .busy(busy_s), .done(done_s));

  // Show-ahead FIFO heads presented from the A matrix, with a forced-empty override.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      fifo_empty[r] = force_empty[r] || (rd_ptr[r] >= C);
      fifo_data[r]  = (rd_ptr[r] < C) ? a_mem[r][rd_ptr[r]] : '0;
    end
  end

  // FIFO pops on rden, with pop and underflow bookkeeping.
  always @(posedge clk) begin
    if (fifo_clear) begin
      for (int r = 0; r < R; r++) begin
        rd_ptr[r]  <= 0;
        pop_cnt[r] <= 0;
      end
      underflow <= 0;
    end else begin
      for (int r = 0; r < R; r++) begin
        if (fifo_rden[r]) begin
          rd_ptr[r]  <= rd_ptr[r] + 1;
          pop_cnt[r] <= pop_cnt[r] + 1;
          if (fifo_empty[r]) underflow <= underflow + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [AW-1:0] modelDot(input int r, input bit sgn);
    longint sum;
    sum = 0;
    for (int k = 0; k < C; k++) begin
      if (sgn) sum += longint'($signed(a_mem[r][k])) * longint'($signed(b_model[k]));
      else     sum += longint'(a_mem[r][k]) * longint'(b_model[k]);
    end
    return sum[AW-1:0];
  endfunction

  task automatic fillA(input int mode);
    for (int r = 0; r < R; r++)
      for (int k = 0; k < C; k++)
        case (mode)
          0: a_mem[r][k] = 8'h01;
          1: a_mem[r][k] = 8'hFF;
          2: a_mem[r][k] = (r == 0) ? 8'hFF : (r == 1) ? 8'h01 : 8'(r * 17 + k);
          3: a_mem[r][k] = 8'(r * 13 + k * 7 + 3);
          default: a_mem[r][k] = 8'(r * 41 + k * 59 + 200);
        endcase
  endtask

  task automatic fillB(input int mode);
    for (int k = 0; k < C; k++)
      case (mode)
        0: b_drive[k] = 8'(k + 1);
        1: b_drive[k] = 8'hFF;
        2: b_drive[k] = 8'h7F;
        3: b_drive[k] = 8'(k * 29 + 5);
        default: b_drive[k] = 8'hA5;
      endcase
  endtask

  // Runs one job; abort_at/reset_at (cycle index, -1 = none) cut it short.
  task automatic applyStimulus(input string name, input bit reuse, input int gap,
                               input int stall_from, input int stall_len,
                               input int abort_at, input int reset_at, input int exp_done);
    exp_t e;
    int   n;
    int   bidx;
    bit   hs;
    bit   finished;
    bit   bready_seen;
    if (!reuse) for (int k = 0; k < C; k++) b_model[k] = b_drive[k];
    if (abort_at < 0 && reset_at < 0) begin
      for (int r = 0; r < R; r++) begin
        e.res_u[r] = modelDot(r, 1'b0);
        e.res_s[r] = modelDot(r, 1'b1);
      end
      e.done_at = 32'(exp_done);
      sb.push_back(e);
    end
    fifo_clear = 1'b1;
    @(posedge clk); #1;
    fifo_clear  = 1'b0;
    start       = 1'b1;
    reuse_b     = reuse;
    n           = 0;
    bidx        = 0;
    finished    = 1'b0;
    bready_seen = 1'b0;
    while (!finished && n < 200) begin
      b_valid     = !reuse && (n >= 1 + gap) && (bidx < C);
      b_data      = (bidx < C) ? b_drive[bidx] : '0;
      force_empty = '0;
      if (n >= stall_from && n < stall_from + stall_len) force_empty[3] = 1'b1;
      abort = (n == abort_at);
      rst_n = (n != reset_at);
      @(negedge clk);
      hs = b_valid && b_ready;
      if (reuse && b_ready) bready_seen = 1'b1;
      if (force_empty[3]) checkOutput({name, " stall rden"}, 64'(fifo_rden), 64'd0);
      @(posedge clk); #1;
      start   = 1'b0;
      reuse_b = 1'b0;
      n++;
      if (hs) bidx++;
      if (n - 1 == abort_at || n - 1 == reset_at) begin
        abort = 1'b0;
        rst_n = 1'b1;
        checkOutput({name, " busy after cut"}, 64'(busy), 64'd0);
        checkOutput({name, " result_valid after cut"}, 64'(result_valid), 64'd0);
        checkOutput({name, " rden after cut"}, 64'(fifo_rden), 64'd0);
        if (reset_at >= 0) begin
          for (int k = 0; k < C; k++) b_model[k] = '0;
          checkOutput({name, " result0 after reset"}, 64'(result[0]), 64'd0);
          checkOutput({name, " result7 after reset"}, 64'(result[7]), 64'd0);
        end
        finished = 1'b1;
      end else if (done) begin
        if (sb.size() == 0) begin
          checkOutput({name, " unexpected done"}, 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({name, " done cycle"}, 64'(n), 64'(e.done_at));
          checkOutput({name, " done signed inst"}, 64'(done_s), 64'd1);
          checkOutput({name, " result_valid in DONE"}, 64'(result_valid), 64'd1);
          for (int r = 0; r < R; r++) begin
            checkOutput($sformatf("%s result[%0d]", name, r), 64'(result[r]), 64'(e.res_u[r]));
            checkOutput($sformatf("%s signed result[%0d]", name, r), 64'(result_s[r]), 64'(e.res_s[r]));
            checkOutput($sformatf("%s pops row %0d", name, r), 64'(pop_cnt[r]), 64'(C));
          end
          checkOutput({name, " underflow pops"}, 64'(underflow), 64'd0);
          if (reuse) checkOutput({name, " b_ready during reuse"}, 64'(bready_seen), 64'd0);
          b_valid     = 1'b0;
          force_empty = '0;
          @(posedge clk); #1;
          checkOutput({name, " done pulse width"}, 64'(done), 64'd0);
          checkOutput({name, " busy after done"}, 64'(busy), 64'd0);
          checkOutput({name, " result_valid held"}, 64'(result_valid), 64'd1);
          checkOutput({name, " result0 held"}, 64'(result[0]), 64'(e.res_u[0]));
        end
        finished = 1'b1;
      end
    end
    if (!finished) checkOutput({name, " timeout"}, 64'd0, 64'd1);
    b_valid     = 1'b0;
    abort       = 1'b0;
    rst_n       = 1'b1;
    force_empty = '0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    reuse_b     = 1'b0;
    abort       = 1'b0;
    b_valid     = 1'b0;
    b_data      = '0;
    force_empty = '0;
    fifo_clear  = 1'b1;
    for (int k = 0; k < C; k++) b_model[k] = '0;
    fillA(0);
    fillB(0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset b_ready", 64'(b_ready), 64'd0);
    checkOutput("reset fifo_rden", 64'(fifo_rden), 64'd0);
    checkOutput("reset result0", 64'(result[0]), 64'd0);
    checkOutput("reset result_valid", 64'(result_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    rst_n      = 1'b1;
    fifo_clear = 1'b0;
    @(posedge clk); #1;

    fillA(0); fillB(0);
    applyStimulus("ones", 1'b0, 0, -1, 0, -1, -1, 26);
    fillA(1); fillB(1);
    applyStimulus("umax", 1'b0, 0, -1, 0, -1, -1, 26);
    fillA(2); fillB(2);
    applyStimulus("signed", 1'b0, 0, -1, 0, -1, -1, 26);
    fillA(3); fillB(3);
    applyStimulus("stall", 1'b0, 0, 13, 5, -1, -1, 31);
    fillA(4); fillB(4);
    applyStimulus("reuse", 1'b1, 0, -1, 0, -1, -1, 18);
    fillA(3); fillB(0);
    applyStimulus("abort", 1'b0, 0, -1, 0, 15, -1, 0);
    fillA(4);
    applyStimulus("reuse after abort", 1'b1, 0, -1, 0, -1, -1, 18);
    fillA(3); fillB(2);
    applyStimulus("b gap", 1'b0, 3, -1, 0, -1, -1, 29);
    applyStimulus("reset", 1'b1, 0, -1, 0, -1, 7, 0);
    fillA(4);
    applyStimulus("reuse after reset", 1'b1, 0, -1, 0, -1, -1, 18);
    fillA(3); fillB(3);
    applyStimulus("fresh", 1'b0, 0, -1, 0, -1, -1, 26);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
